// File: rtl/multi_servo_tester_pkg.sv
// Shared definitions for the multi-channel servo tester: pulse-width
// width, controller state encoding and channel-index width helper.
package multi_servo_tester_pkg;

    // Width of every pulse-width value in microseconds.
    localparam int PW_W = 16;

    // Controller modes: manual stepping, or auto-sweep in either direction.
    typedef enum logic [1:0] {
        MANUAL   = 2'd0,
        SWEEP_UP = 2'd1,
        SWEEP_DN = 2'd2
    } servo_state_t;

    // Width of a channel index; at least one bit even for a single channel.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_servo_tester_pwm_channel.sv
// One servo PWM output. The requested pulse width is captured into a shadow
// register only at the frame boundary, so a pulse is never cut short or
// stretched part-way through a frame.
module multi_servo_tester_pwm_channel
    import multi_servo_tester_pkg::*;
#(
    parameter int US_W      = 15,
    parameter int PW_CENTRE = 1500
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic [PW_W-1:0] i_pulse_len,
    input  logic [US_W-1:0] i_us_cnt_next,
    output logic            o_pin
);

    logic [PW_W-1:0] r_shadow;
    logic [PW_W-1:0] w_shadow_next;

    // The compare uses the values the registers are about to take, so the pin
    // is aligned with the frame counter rather than lagging it by a cycle.
    assign w_shadow_next = i_load ? i_pulse_len : r_shadow;

    // Shadow capture at the frame boundary and registered pulse compare.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow <= PW_W'(PW_CENTRE);
            o_pin    <= 1'b0;
        end else begin
            r_shadow <= w_shadow_next;
            o_pin    <= (int'(i_us_cnt_next) < int'(w_shadow_next));
        end
    end

endmodule

// File: rtl/multi_servo_tester.sv
// N-channel RC-servo tester: shared microsecond frame timebase, channel
// select, manual pulse-width stepping and an auto-sweep mode.
module multi_servo_tester
    import multi_servo_tester_pkg::*;
#(
    parameter int CLK_MHZ    = 100,
    parameter int N_CH       = 4,
    parameter int FRAME_US   = 20000,
    parameter int PW_MIN     = 1000,
    parameter int PW_MAX     = 2000,
    parameter int PW_CENTRE  = 1500,
    parameter int STEP       = 100,
    parameter int SWEEP_STEP = 10
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    sw_up,
    input  logic                    sw_dn,
    input  logic                    sw_sel,
    input  logic                    sw_mode,
    output logic [N_CH-1:0]         CONTROL_PIN,
    output logic [ch_w(N_CH)-1:0]   ch_sel,
    output logic                    sweep_active,
    output logic                    frame_start
);

    localparam int CH_W = ch_w(N_CH);
    localparam int PS_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int US_W = $clog2(FRAME_US);

    logic [PS_W-1:0] r_presc;
    logic [US_W-1:0] r_us_cnt;
    logic [US_W-1:0] w_us_cnt_next;
    logic            w_us_tick;
    logic            w_wrap;
    logic            r_frame_start;

    logic [CH_W-1:0] r_ch_sel;
    servo_state_t    r_state;
    logic [PW_W-1:0] r_pulse_len [N_CH];

    logic [PW_W-1:0] w_p;
    logic [16:0]     w_man_sum, w_man_diff, w_swp_sum, w_swp_diff;
    logic [PW_W-1:0] w_man_up, w_man_dn, w_swp_up, w_swp_dn;
    logic            w_swp_ceil, w_swp_floor;

    assign w_us_tick = (r_presc == PS_W'(CLK_MHZ - 1));
    assign w_wrap    = w_us_tick && (r_us_cnt == US_W'(FRAME_US - 1));
    assign w_us_cnt_next = !w_us_tick ? r_us_cnt :
                           (w_wrap ? '0 : r_us_cnt + US_W'(1));

    // Saturating arithmetic on the selected channel in 17 bits so neither
    // the add nor the subtract can wrap before it is clamped.
    assign w_p        = r_pulse_len[r_ch_sel];
    assign w_man_sum  = {1'b0, w_p} + 17'(STEP);
    assign w_man_diff = {1'b0, w_p} - 17'(STEP);
    assign w_swp_sum  = {1'b0, w_p} + 17'(SWEEP_STEP);
    assign w_swp_diff = {1'b0, w_p} - 17'(SWEEP_STEP);

    assign w_man_up    = (w_man_sum > 17'(PW_MAX)) ? PW_W'(PW_MAX) : w_man_sum[PW_W-1:0];
    assign w_man_dn    = (w_man_diff[16] || w_man_diff < 17'(PW_MIN)) ? PW_W'(PW_MIN)
                                                                       : w_man_diff[PW_W-1:0];
    assign w_swp_ceil  = (w_swp_sum >= 17'(PW_MAX));
    assign w_swp_floor = w_swp_diff[16] || (w_swp_diff <= 17'(PW_MIN));
    assign w_swp_up    = w_swp_ceil  ? PW_W'(PW_MAX) : w_swp_sum[PW_W-1:0];
    assign w_swp_dn    = w_swp_floor ? PW_W'(PW_MIN) : w_swp_diff[PW_W-1:0];

    // Microsecond prescaler and frame counter; frame_start marks the first
    // cycle of a new frame.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_presc       <= '0;
            r_us_cnt      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_presc       <= w_us_tick ? '0 : r_presc + PS_W'(1);
            r_us_cnt      <= w_us_cnt_next;
            r_frame_start <= w_wrap;
        end
    end

    // Channel select, mode FSM and per-channel pulse-width updates. Adjusts
    // and sweep steps always act on the channel selected before this edge;
    // a select during sweep restarts the sweep upward on the new channel.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_ch_sel <= '0;
            r_state  <= MANUAL;
            for (int i = 0; i < N_CH; i++) begin
                r_pulse_len[i] <= PW_W'(PW_CENTRE);
            end
        end else begin
            if (r_state == MANUAL) begin
                if (sw_up && !sw_dn) begin
                    r_pulse_len[r_ch_sel] <= w_man_up;
                end else if (sw_dn && !sw_up) begin
                    r_pulse_len[r_ch_sel] <= w_man_dn;
                end
                if (sw_mode) begin
                    r_state <= SWEEP_UP;
                end
            end else if (sw_mode) begin
                // Leaving sweep keeps whatever width was reached; a
                // coinciding frame step is dropped.
                r_state <= MANUAL;
            end else begin
                if (r_frame_start) begin
                    if (r_state == SWEEP_DN) begin
                        r_pulse_len[r_ch_sel] <= w_swp_dn;
                        if (w_swp_floor) begin
                            r_state <= SWEEP_UP;
                        end
                    end else begin
                        r_pulse_len[r_ch_sel] <= w_swp_up;
                        if (w_swp_ceil) begin
                            r_state <= SWEEP_DN;
                        end
                    end
                end
                if (sw_sel) begin
                    r_state <= SWEEP_UP;
                end
            end
            if (sw_sel) begin
                r_ch_sel <= (r_ch_sel == CH_W'(N_CH - 1)) ? '0 : r_ch_sel + CH_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        multi_servo_tester_pwm_channel #(
            .US_W      (US_W),
            .PW_CENTRE (PW_CENTRE)
        ) u_ch (
            .i_clk         (CLK),
            .i_rst_n       (RESETN),
            .i_load        (w_wrap),
            .i_pulse_len   (r_pulse_len[gi]),
            .i_us_cnt_next (w_us_cnt_next),
            .o_pin         (CONTROL_PIN[gi])
        );
    end

    assign ch_sel       = r_ch_sel;
    assign frame_start  = r_frame_start;
    assign sweep_active = (r_state != MANUAL);

endmodule

// File: tb/tb_multi_servo_tester.sv
// Scoreboard bench for multi_servo_tester with a short frame (2 MHz, 3 ms).
// The driver updates an abstract model on every clock and queues expected
// pulse widths, frame starts and status; a monitor measures the DUT and pops.
module tb_multi_servo_tester;

    localparam int CLK_MHZ    = 2;
    localparam int N_CH       = 4;
    localparam int FRAME_US   = 3000;
    localparam int PW_MIN     = 1000;
    localparam int PW_MAX     = 2000;
    localparam int PW_CENTRE  = 1500;
    localparam int STEP       = 100;
    localparam int SWEEP_STEP = 10;
    localparam int FRAME_CLK  = CLK_MHZ * FRAME_US;

    logic            CLK     = 1'b0;
    logic            RESETN  = 1'b1;
    logic            sw_up   = 1'b0;
    logic            sw_dn   = 1'b0;
    logic            sw_sel  = 1'b0;
    logic            sw_mode = 1'b0;
    logic [N_CH-1:0] CONTROL_PIN;
    logic [1:0]      ch_sel;
    logic            sweep_active;
    logic            frame_start;

    multi_servo_tester #(
        .CLK_MHZ (CLK_MHZ),
        .N_CH    (N_CH),
        .FRAME_US(FRAME_US)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .sw_up       (sw_up),
        .sw_dn       (sw_dn),
        .sw_sel      (sw_sel),
        .sw_mode     (sw_mode),
        .CONTROL_PIN (CONTROL_PIN),
        .ch_sel      (ch_sel),
        .sweep_active(sweep_active),
        .frame_start (frame_start)
    );

    always #5 CLK = ~CLK;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;   // rising edges since reset release
    int last_e = 0;   // edge number the current inputs are aimed at
    bit mon_en = 1'b0;

    // Abstract model: widths in microseconds, selection, mode, sweep direction.
    int m_pw [N_CH];
    int m_sel;
    int m_dir;
    bit m_sweep;

    typedef struct {
        int edge_n;
        int sel;
        int sweep;
    } st_t;

    int  exp_w [N_CH][$];
    int  exp_fs[$];
    st_t exp_st[$];

    always @(posedge CLK) cyc <= RESETN ? cyc + 1 : 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Effect of one rising edge (number e) with the given button pulses.
    task automatic model_edge(input bit up, input bit dn, input bit sel, input bit mode, input int e);
        if (e % FRAME_CLK == 0) begin
            for (int ch = 0; ch < N_CH; ch++) exp_w[ch].push_back(CLK_MHZ * m_pw[ch]);
            exp_fs.push_back(e);
        end
        if (!m_sweep) begin
            if (up && !dn)
                m_pw[m_sel] = (m_pw[m_sel] + STEP > PW_MAX) ? PW_MAX : m_pw[m_sel] + STEP;
            else if (dn && !up)
                m_pw[m_sel] = (m_pw[m_sel] - STEP < PW_MIN) ? PW_MIN : m_pw[m_sel] - STEP;
            if (mode) begin
                m_sweep = 1'b1;
                m_dir   = 1;
            end
        end else if (mode) begin
            m_sweep = 1'b0;
        end else begin
            // frame_start is visible in the cycle right after a boundary edge
            if ((e - 1) >= FRAME_CLK && (e - 1) % FRAME_CLK == 0) begin
                m_pw[m_sel] += m_dir * SWEEP_STEP;
                if (m_dir > 0 && m_pw[m_sel] >= PW_MAX) begin
                    m_pw[m_sel] = PW_MAX;
                    m_dir = -1;
                end else if (m_dir < 0 && m_pw[m_sel] <= PW_MIN) begin
                    m_pw[m_sel] = PW_MIN;
                    m_dir = 1;
                end
            end
            if (sel) m_dir = 1;
        end
        if (sel) m_sel = (m_sel + 1) % N_CH;
        if (up || dn || sel || mode) exp_st.push_back('{e, m_sel, int'(m_sweep)});
    endtask

    task automatic drive(input bit up, input bit dn, input bit sel, input bit mode);
        @(negedge CLK);
        sw_up   = up;
        sw_dn   = dn;
        sw_sel  = sel;
        sw_mode = mode;
        last_e  = cyc + 1;
        model_edge(up, dn, sel, mode, last_e);
    endtask

    // Idle so that the next drive() call targets edge t.
    task automatic idle_until(input int t);
        while (last_e < t - 1) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        sw_up = 1'b0; sw_dn = 1'b0; sw_sel = 1'b0; sw_mode = 1'b0;
        RESETN = 1'b0;
        #1;
        check("pins_low_on_reset_edge", int'(CONTROL_PIN), 0);
        for (int ch = 0; ch < N_CH; ch++) begin
            exp_w[ch].delete();
            m_pw[ch] = PW_CENTRE;
        end
        exp_fs.delete();
        exp_st.delete();
        m_sel = 0; m_dir = 1; m_sweep = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_pins", int'(CONTROL_PIN), 0);
        check("rst_ch_sel", int'(ch_sel), 0);
        check("rst_sweep_active", int'(sweep_active), 0);
        check("rst_frame_start", int'(frame_start), 0);
        RESETN = 1'b1;
        last_e = 1;
        mon_en = 1'b1;
    endtask

    // Monitor: samples just after each rising edge.
    initial begin
        bit armed [N_CH];
        int hi    [N_CH];
        st_t st;
        int  exp;
        for (int ch = 0; ch < N_CH; ch++) begin armed[ch] = 1'b0; hi[ch] = 0; end
        forever begin
            @(posedge CLK);
            #1;
            if (!RESETN || !mon_en) begin
                for (int ch = 0; ch < N_CH; ch++) armed[ch] = 1'b0;
            end else begin
                if (exp_fs.size() > 0 && exp_fs[0] == cyc) begin
                    check("frame_start", int'(frame_start), 1);
                    void'(exp_fs.pop_front());
                end else if (frame_start !== 1'b0) begin
                    check("frame_start_spurious", int'(frame_start), 0);
                end
                for (int ch = 0; ch < N_CH; ch++) begin
                    if (frame_start && CONTROL_PIN[ch]) begin
                        armed[ch] = 1'b1;
                        hi[ch]    = 1;
                    end else if (armed[ch]) begin
                        if (CONTROL_PIN[ch]) begin
                            hi[ch]++;
                        end else begin
                            armed[ch] = 1'b0;
                            exp = (exp_w[ch].size() > 0) ? exp_w[ch].pop_front() : -1;
                            $display("[TB] edge %0d ch%0d pulse %0d clk (expected %0d)", cyc, ch, hi[ch], exp);
                            check($sformatf("width_ch%0d", ch), hi[ch], exp);
                        end
                    end
                end
                if (exp_st.size() > 0 && exp_st[0].edge_n == cyc) begin
                    st = exp_st.pop_front();
                    $display("[TB] edge %0d status ch_sel=%0d sweep=%0d (expected %0d/%0d)",
                             cyc, ch_sel, sweep_active, st.sel, st.sweep);
                    check("ch_sel", int'(ch_sel), st.sel);
                    check("sweep_active", int'(sweep_active), st.sweep);
                end
            end
        end
    end

    initial begin
        int r;
        do_reset();

        // Two undisturbed frames at the centre width.
        idle_until(FRAME_CLK + 600);
        // Three ups on ch0 mid-pulse: current frame stays 1500, next is 1800.
        repeat (3) begin drive(1, 0, 0, 0); drive(0, 0, 0, 0); end
        idle_until(2 * FRAME_CLK + 100);
        // Saturate ch0 upward; up+dn together must not move it.
        repeat (8) begin drive(1, 0, 0, 0); drive(0, 0, 0, 0); end
        drive(1, 1, 0, 0);
        idle_until(3 * FRAME_CLK + 100);
        // Saturate ch0 downward, then up+sel at ch_sel=3, then ch1 to the top.
        repeat (15) begin drive(0, 1, 0, 0); drive(0, 0, 0, 0); end
        repeat (3) drive(0, 0, 1, 0);
        drive(1, 0, 1, 0);
        drive(0, 0, 1, 0);
        repeat (5) drive(1, 0, 0, 0);
        // Sweep ch1 from the ceiling so it reverses, then move the sweep to ch2.
        drive(0, 0, 0, 1);
        idle_until(5 * FRAME_CLK + 100);
        drive(1, 1, 0, 0);
        drive(0, 0, 1, 0);
        // Leave sweep exactly in the frame_start cycle; then manual up works.
        idle_until(8 * FRAME_CLK + 1);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        // Random button traffic.
        while (last_e < 9 * FRAME_CLK - 100) begin
            r = $urandom_range(0, 15);
            if ($urandom_range(0, 39) == 0)
                drive(r[0], r[1], r[2], r[3] && ($urandom_range(0, 2) == 0));
            else
                drive(0, 0, 0, 0);
        end
        // Reset in the middle of the pulses of a frame.
        idle_until(10 * FRAME_CLK + 1001);
        check("pins_high_before_reset", int'(CONTROL_PIN), (1 << N_CH) - 1);
        do_reset();
        idle_until(FRAME_CLK + 4100);

        for (int ch = 0; ch < N_CH; ch++)
            check($sformatf("unmatched_pulses_ch%0d", ch), exp_w[ch].size(), 0);
        check("unmatched_frame_starts", exp_fs.size(), 0);
        check("unmatched_status", exp_st.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
